seg_scan: RTL

Parametrised multiplexed seven-segment display driver, the next generation of the board's 4-digit hex scanner. It drives `DIGITS` common-anode or common-cathode digits from a packed hex value, with per-digit decimal points and blanking, and optional leading-zero suppression. It adds 16-level PWM brightness and tear-free double-buffered updates that are committed only at frame boundaries. It sits between game/score logic and the board's `segment`/`an` pins.

---
 rtl/seg_scan.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/seg_scan.sv
// seg_scan: multiplexed seven-segment display driver with PWM brightness,
// leading-zero suppression, per-digit dp/blanking and frame-aligned
// double-buffered display data.
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-high reset
//   disp_num  packed hex nibbles, nibble i drives digit i (digit 0 rightmost)
//   dpdot     per-digit decimal point enables
//   blank     per-digit force-dark
//   lz_blank  leading-zero suppression enable (unbuffered)
//   bright    PWM duty level 0..15 (unbuffered)
//   load      strobe capturing disp_num/dpdot/blank into the shadow register
//   segment   registered segment byte, [6:0]=g..a, [7]=dp
//   an        registered digit enables
//   frame     1-cycle pulse following each digit-index wrap
module seg_scan #(
   parameter int unsigned DIGITS         = 4,
   parameter int unsigned DIV_BITS       = 13,
   parameter int unsigned AN_ACTIVE_LOW  = 1,
   parameter int unsigned SEG_ACTIVE_LOW = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   disp_num,
   input  logic [DIGITS-1:0]     dpdot,
   input  logic [DIGITS-1:0]     blank,
   input  logic                  lz_blank,
   input  logic [3:0]            bright,
   input  logic                  load,
   output logic [7:0]            segment,
   output logic [DIGITS-1:0]     an,
   output logic                  frame
);

   localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned NUM_W = 4 * DIGITS;
   localparam logic [7:0]        SEG_DARK = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
   localparam logic [DIGITS-1:0] AN_OFF   = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);

   logic [DIV_BITS-1:0] cnt;
   logic [IDX_W-1:0]    idx;
   logic                tick;
   logic                frame_tick;

   logic [NUM_W-1:0]    shadow_num;
   logic [DIGITS-1:0]   shadow_dp;
   logic [DIGITS-1:0]   shadow_blank;
   logic [NUM_W-1:0]    act_num;
   logic [DIGITS-1:0]   act_dp;
   logic [DIGITS-1:0]   act_blank;

   logic [DIGITS-1:0]   sup_vec;
   logic                lead;
   logic [3:0]          nib;
   logic                dp_sel;
   logic                blank_sel;
   logic                sup_sel;
   logic                pwm_on;
   logic [7:0]          seg_lit;
   logic [DIGITS-1:0]   an_en;
   logic [7:0]          seg_next;
   logic [DIGITS-1:0]   an_next;

   // Active-low g..a patterns for hex digits
   function automatic logic [6:0] dec_low(input logic [3:0] n);
      logic [6:0] r;
      case (n)
         4'h0: r = 7'b1000000;
         4'h1: r = 7'b1111001;
         4'h2: r = 7'b0100100;
         4'h3: r = 7'b0110000;
         4'h4: r = 7'b0011001;
         4'h5: r = 7'b0010010;
         4'h6: r = 7'b0000010;
         4'h7: r = 7'b1111000;
         4'h8: r = 7'b0000000;
         4'h9: r = 7'b0010000;
         4'hA: r = 7'b0001000;
         4'hB: r = 7'b0000011;
         4'hC: r = 7'b1000110;
         4'hD: r = 7'b0100001;
         4'hE: r = 7'b0000110;
         default: r = 7'b0001110;
      endcase
      return r;
   endfunction

   assign tick       = &cnt;
   assign frame_tick = tick && (idx == IDX_LAST);

   // Prescaler and digit index
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         idx <= '0;
      end else begin
         cnt <= cnt + DIV_BITS'(1);
         if (tick) begin
            idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
         end
      end
   end

   // Shadow/active buffers; a load on the wrap cycle bypasses the shadow
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_num   <= '0;
         shadow_dp    <= '0;
         shadow_blank <= '0;
         act_num      <= '0;
         act_dp       <= '0;
         act_blank    <= '0;
      end else begin
         if (load) begin
            shadow_num   <= disp_num;
            shadow_dp    <= dpdot;
            shadow_blank <= blank;
         end
         if (frame_tick) begin
            act_num   <= load ? disp_num : shadow_num;
            act_dp    <= load ? dpdot    : shadow_dp;
            act_blank <= load ? blank    : shadow_blank;
         end
      end
   end

   // Leading zeros: digit i is suppressed when it and every digit above are zero
   always_comb begin
      sup_vec = '0;
      lead    = lz_blank;
      for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
         lead       = lead & (act_num[4*i +: 4] == 4'd0);
         sup_vec[i] = lead;
      end
   end

   // Select the current digit's data
   always_comb begin
      nib       = '0;
      dp_sel    = 1'b0;
      blank_sel = 1'b0;
      sup_sel   = 1'b0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (idx == IDX_W'(i)) begin
            nib       = act_num[4*i +: 4];
            dp_sel    = act_dp[i];
            blank_sel = act_blank[i];
            sup_sel   = sup_vec[i];
         end
      end
   end

   assign pwm_on = (cnt[DIV_BITS-1 -: 4] <= bright);

   // Lit-form segment/anode, dark whenever the anode is off
   always_comb begin
      seg_lit = '0;
      an_en   = '0;
      if (!blank_sel && pwm_on) begin
         an_en        = DIGITS'(1) << idx;
         seg_lit[6:0] = sup_sel ? 7'h00 : ~dec_low(nib);
         seg_lit[7]   = dp_sel;
      end
      seg_next = (SEG_ACTIVE_LOW != 0) ? ~seg_lit : seg_lit;
      an_next  = (AN_ACTIVE_LOW  != 0) ? ~an_en   : an_en;
   end

   // Output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         segment <= SEG_DARK;
         an      <= AN_OFF;
         frame   <= 1'b0;
      end else begin
         segment <= seg_next;
         an      <= an_next;
         frame   <= frame_tick;
      end
   end

endmodule
